rst_chain_monitor: RTL and testbench
====================================

# rst_chain_monitor

Supervises the staged reset-release chain on the 25 MHz reference clock. It synchronises the four reset outputs of the clock/reset manager (DDR-config, DDR, system, core) into the CLK_25M domain and checks that they release in the required order within a time bound. It measures total bring-up time, detects reset re-assertion or out-of-order release as faults, and drives status and heartbeat outputs for LEDs and debug registers.

## Interface
Parameters:
- TIMEOUT_CYC, 4096: max CLK_25M edges allowed in any single WAIT state.
- CNT_W, 16: width of the bring-up time counter.
- HB_DIV, 12_500_000: heartbeat half-period in CLK_25M edges (1 Hz at 25 MHz).

Ports:
- CLK_25M  in  1  clock, 25 MHz.
- rstn_sig  in  1  reset, asynchronous, active-low.
- i_ddr_cfg_rstn  in  1  DDR-config reset, active-low, foreign domain.
- i_ddr_rstn  in  1  DDR reset, active-low, foreign domain.
- i_sys_rstn  in  1  system reset, active-low, foreign domain.
- i_core_reset  in  1  core reset, active-high, foreign domain.
- i_clr_fault  in  1  CLK_25M-synchronous pulse; clears sticky status.
- o_stage  out  3  FSM state encoding.
- o_all_ready  out  1  high when the FSM is in DONE.
- o_timeout  out  1  sticky timeout flag.
- o_fault  out  1  sticky fault flag.
- o_fault_cnt  out  8  fault occurrences, saturating at 255.
- o_total_cyc  out  CNT_W  bring-up time in edges, saturating.
- o_heartbeat  out  1  free-running toggle.

## Operation
**Synchronisers**
- One 2-flop synchroniser per input.
- Reset values: rstn inputs reset to 0; i_core_reset resets to 1.
- Ready vector rdy[3:0] = {~core_s, sys_s, ddr_s, cfg_s}.

**FSM (o_stage encoding)**
- States: WAIT_CFG=0, WAIT_DDR=1, WAIT_SYS=2, WAIT_CORE=3, DONE=4, TIMEOUT=5. Reset state is WAIT_CFG.
- WAIT_n → next state when rdy[n]=1.
- stage_cnt clears on every state entry and increments each edge in a WAIT state.
- If stage_cnt reaches TIMEOUT_CYC-1 with rdy[n] still 0: go to TIMEOUT and set o_timeout.
- TIMEOUT: leave only when rdy==4'b1111, then go to DONE. o_timeout stays set.
- DONE: any rdy bit dropping to 0 is a fault. Go to WAIT_CFG, clear o_total_cyc, and restart measurement.

**Faults**
- A fault is a DONE-state drop, or an order violation: rdy[j]=1 while some rdy[i]=0 with i<j, in any WAIT state.
- An order violation is counted once, on the rising edge of the violation condition.
- On a fault: o_fault←1 and o_fault_cnt←min(o_fault_cnt+1, 255).
- If a fault and i_clr_fault occur on the same edge, the fault wins: o_fault=1 and o_fault_cnt=1.
- i_clr_fault clears o_fault, o_timeout and o_fault_cnt. It does not change FSM state.

**o_total_cyc**
- Increments on every edge whose current state is WAIT_* or TIMEOUT.
- Saturates at all-ones and is frozen in DONE.

**o_heartbeat**
- Toggles every HB_DIV edges, independent of the FSM.

**Reset values**
- All outputs are 0 during reset, except o_stage=0 (WAIT_CFG).

## Timing
- An input change sampled at edge k appears in rdy after edge k+1. The state updates at edge k+2.
- o_stage and o_all_ready are registered with the state, so they change at edge k+2.
- o_fault and o_fault_cnt update on the same edge as the state transition that detects the fault.
- Asserting rstn_sig mid-operation clears all state and outputs immediately (asynchronous). Counting restarts on the first edge after release.
- An input pulse shorter than 2 CLK_25M periods may be missed. This is accepted.

## Test plan
- **Nominal bring-up.** Release cfg, ddr, sys and core (i_core_reset→0) sampled at edges 10, 20, 30, 40, counting edge 1 as the first edge after rstn_sig release.
  - o_stage must go 1@12, 2@22, 3@32, 4@42.
  - o_all_ready must rise at edge 42, with o_total_cyc=42, o_fault=0 and o_timeout=0.
- **Timeout.** TIMEOUT_CYC=64; release cfg only.
  - o_stage must be 5 and o_timeout=1 exactly 64 edges after WAIT_DDR entry.
  - Releasing the remaining inputs must give o_stage=4 with o_timeout still 1.
- **Post-DONE glitch.** Drop i_sys_rstn for 5 edges, then release.
  - o_fault=1, o_fault_cnt=1, o_stage→0, then the FSM returns to DONE.
  - o_total_cyc must be re-measured.
  - A later i_clr_fault pulse must clear o_fault and o_fault_cnt.
- **Order violation.** Release i_sys_rstn while i_ddr_cfg_rstn=0, held for 50 edges.
  - o_fault_cnt must be exactly 1, not 50.
- **Reset mid-WAIT_SYS.** Assert rstn_sig.
  - All outputs must be at reset values before the next edge.
  - After release, the sequence must restart from WAIT_CFG with o_total_cyc counting from 0.
- **Saturation and heartbeat.** Apply 300 DONE glitches: o_fault_cnt must be 255. With HB_DIV=4, o_heartbeat must toggle every 4 edges.

Source files
------------

// File: rtl/rst_chain_monitor.sv
`timescale 1ns/1ps
// Supervises the staged reset-release chain (DDR-config, DDR, system, core) on CLK_25M:
// ordering, per-stage timeout, bring-up time, sticky fault status and a heartbeat.
module rst_chain_monitor #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16,
  parameter int HB_DIV      = 12_500_000
) (
  input  logic             CLK_25M,
  input  logic             rstn_sig,
  input  logic             i_ddr_cfg_rstn,
  input  logic             i_ddr_rstn,
  input  logic             i_sys_rstn,
  input  logic             i_core_reset,
  input  logic             i_clr_fault,
  output logic [2:0]       o_stage,
  output logic             o_all_ready,
  output logic             o_timeout,
  output logic             o_fault,
  output logic [7:0]       o_fault_cnt,
  output logic [CNT_W-1:0] o_total_cyc,
  output logic             o_heartbeat
);

  localparam int SC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(TIMEOUT_CYC - 1);
  localparam int HB_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_DIV - 1);
  localparam logic [CNT_W-1:0] TOTAL_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    WAIT_CFG  = 3'd0,
    WAIT_DDR  = 3'd1,
    WAIT_SYS  = 3'd2,
    WAIT_CORE = 3'd3,
    DONE      = 3'd4,
    TIMEOUT   = 3'd5
  } state_t;

  state_t          state;
  logic [3:0]      meta;
  logic [3:0]      sync;
  logic [3:0]      rdy;
  logic [SC_W-1:0] stage_cnt;
  logic [HB_W-1:0] hb_cnt;
  logic            viol_raw;
  logic            viol_q;
  logic            in_wait;
  logic            all_rdy;
  logic            fault_done;
  logic            fault_ord;
  logic            fault_evt;
  logic            timeout_evt;

  // Bit 3 carries the active-high core reset, so its flops reset to 1 (held in reset).
  always_ff @(posedge CLK_25M or negedge rstn_sig) begin
    if (!rstn_sig) begin
      meta <= 4'b1000;
      sync <= 4'b1000;
    end else begin
      meta <= {i_core_reset, i_sys_rstn, i_ddr_rstn, i_ddr_cfg_rstn};
      sync <= meta;
    end
  end

  assign rdy      = {~sync[3], sync[2:0]};
  assign all_rdy  = &rdy;
  assign in_wait  = (state == WAIT_CFG) || (state == WAIT_DDR) ||
                    (state == WAIT_SYS) || (state == WAIT_CORE);
  assign viol_raw = (rdy[1] & ~rdy[0]) | (rdy[2] & ~&rdy[1:0]) | (rdy[3] & ~&rdy[2:0]);

  // The violation edge is tracked in every state, so a drop already counted as a
  // DONE fault does not count again once the FSM falls back into WAIT_CFG.
  assign fault_ord   = in_wait && viol_raw && !viol_q;
  assign fault_done  = (state == DONE) && !all_rdy;
  assign fault_evt   = fault_ord || fault_done;
  assign timeout_evt = in_wait && !rdy[state[1:0]] && (stage_cnt == SC_LAST);

  always_ff @(posedge CLK_25M or negedge rstn_sig) begin
    if (!rstn_sig) begin
      state       <= WAIT_CFG;
      stage_cnt   <= '0;
      o_all_ready <= 1'b0;
      o_total_cyc <= '0;
      o_timeout   <= 1'b0;
      o_fault     <= 1'b0;
      o_fault_cnt <= 8'd0;
      viol_q      <= 1'b0;
    end else begin
      viol_q <= viol_raw;

      case (state)
        WAIT_CFG, WAIT_DDR, WAIT_SYS, WAIT_CORE: begin
          if (rdy[state[1:0]]) begin
            state     <= state_t'(state + 3'd1);
            stage_cnt <= '0;
            if (state == WAIT_CORE) o_all_ready <= 1'b1;
          end else if (timeout_evt) begin
            state     <= TIMEOUT;
            stage_cnt <= '0;
          end else begin
            stage_cnt <= stage_cnt + SC_W'(1);
          end
        end
        TIMEOUT: begin
          if (all_rdy) begin
            state       <= DONE;
            o_all_ready <= 1'b1;
          end
        end
        DONE: begin
          if (!all_rdy) begin
            state       <= WAIT_CFG;
            stage_cnt   <= '0;
            o_all_ready <= 1'b0;
          end
        end
        default: begin
          state       <= WAIT_CFG;
          stage_cnt   <= '0;
          o_all_ready <= 1'b0;
        end
      endcase

      if (fault_done) begin
        o_total_cyc <= '0;
      end else if (state != DONE && o_total_cyc != TOTAL_MAX) begin
        o_total_cyc <= o_total_cyc + CNT_W'(1);
      end

      if (timeout_evt) begin
        o_timeout <= 1'b1;
      end else if (i_clr_fault) begin
        o_timeout <= 1'b0;
      end

      // A fault on the same edge as a clear wins and restarts the count at one.
      if (fault_evt) begin
        o_fault <= 1'b1;
        if (i_clr_fault) begin
          o_fault_cnt <= 8'd1;
        end else if (o_fault_cnt != 8'd255) begin
          o_fault_cnt <= o_fault_cnt + 8'd1;
        end
      end else if (i_clr_fault) begin
        o_fault     <= 1'b0;
        o_fault_cnt <= 8'd0;
      end
    end
  end

  assign o_stage = state;

  always_ff @(posedge CLK_25M or negedge rstn_sig) begin
    if (!rstn_sig) begin
      hb_cnt      <= '0;
      o_heartbeat <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt      <= '0;
      o_heartbeat <= ~o_heartbeat;
    end else begin
      hb_cnt <= hb_cnt + HB_W'(1);
    end
  end

endmodule

// File: tb/tb_rst_chain_monitor.sv
`timescale 1ns/1ps
// Directed bench for rst_chain_monitor: bring-up, timeout, DONE glitches, order
// violations, asynchronous reset, fault-count saturation and heartbeat.
module tb_rst_chain_monitor;

  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_W       = 16;
  localparam int HB_DIV      = 4;

  logic             clk = 1'b0;
  logic             rstn_sig;
  logic             ddr_cfg_rstn;
  logic             ddr_rstn;
  logic             sys_rstn;
  logic             core_reset;
  logic             clr_fault;
  logic [2:0]       stage;
  logic             all_ready;
  logic             timeout;
  logic             fault;
  logic [7:0]       fault_cnt;
  logic [CNT_W-1:0] total_cyc;
  logic             heartbeat;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  rst_chain_monitor #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W),
    .HB_DIV     (HB_DIV)
  ) dut (
    .CLK_25M       (clk),
    .rstn_sig      (rstn_sig),
    .i_ddr_cfg_rstn(ddr_cfg_rstn),
    .i_ddr_rstn    (ddr_rstn),
    .i_sys_rstn    (sys_rstn),
    .i_core_reset  (core_reset),
    .i_clr_fault   (clr_fault),
    .o_stage       (stage),
    .o_all_ready   (all_ready),
    .o_timeout     (timeout),
    .o_fault       (fault),
    .o_fault_cnt   (fault_cnt),
    .o_total_cyc   (total_cyc),
    .o_heartbeat   (heartbeat)
  );

  // Clock / watchdog
  always #20 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic reset_with(input logic cfg, input logic ddr, input logic sys, input logic core_rst);
    @(negedge clk);
    rstn_sig     = 1'b0;
    ddr_cfg_rstn = cfg;
    ddr_rstn     = ddr;
    sys_rstn     = sys;
    core_reset   = core_rst;
    clr_fault    = 1'b0;
    tick();
    @(negedge clk);
    rstn_sig = 1'b1;
    edge_n   = 0;
  endtask

  task automatic wait_stage(input logic [2:0] s, input int budget);
    int n = 0;
    while (stage !== s && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard
  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      e = 32'hDEAD_BEEF;
      t = "empty_queue";
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
    end
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %0d expected %0d", t, edge_n, obs, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
    expect_v(tag, v);
    check(obs);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stage"},     stage,     0);
    chk({tag, "_all_ready"}, all_ready, 0);
    chk({tag, "_timeout"},   timeout,   0);
    chk({tag, "_fault"},     fault,     0);
    chk({tag, "_fault_cnt"}, fault_cnt, 0);
    chk({tag, "_total"},     total_cyc, 0);
    chk({tag, "_hb"},        heartbeat, 0);
  endtask

  initial begin
    rstn_sig     = 1'b0;
    ddr_cfg_rstn = 1'b0;
    ddr_rstn     = 1'b0;
    sys_rstn     = 1'b0;
    core_reset   = 1'b1;
    clr_fault    = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("por");
    @(negedge clk);
    rstn_sig = 1'b1;
    edge_n   = 0;

    // Nominal bring-up: releases sampled at edges 10/20/30/40
    for (int e = 1; e <= 42; e++) begin
      expect_v("nom_stage", (e >= 42) ? 4 : (e >= 32) ? 3 : (e >= 22) ? 2 : (e >= 12) ? 1 : 0);
      expect_v("nom_total", e);
      expect_v("nom_hb", (e / HB_DIV) % 2);
    end
    for (int e = 1; e <= 42; e++) begin
      if (e == 10) ddr_cfg_rstn = 1'b1;
      if (e == 20) ddr_rstn = 1'b1;
      if (e == 30) sys_rstn = 1'b1;
      if (e == 40) core_reset = 1'b0;
      tick();
      check(stage);
      check(total_cyc);
      check(heartbeat);
    end
    chk("nom_all_ready", all_ready, 1);
    chk("nom_fault", fault, 0);
    chk("nom_timeout", timeout, 0);
    repeat (3) tick();
    chk("nom_total_frozen", total_cyc, 42);
    chk("nom_stage_hold", stage, 4);

    // Post-DONE glitch: sys low for 5 sampled edges
    sys_rstn = 1'b0;
    tick();
    tick();
    chk("gl_stage_pre", stage, 4);
    chk("gl_fault_pre", fault, 0);
    tick();
    chk("gl_stage_drop", stage, 0);
    chk("gl_fault", fault, 1);
    chk("gl_fault_cnt", fault_cnt, 1);
    chk("gl_total_clr", total_cyc, 0);
    chk("gl_all_ready", all_ready, 0);
    tick();
    chk("gl_stage_ddr", stage, 1);
    chk("gl_total_1", total_cyc, 1);
    tick();
    chk("gl_stage_sys", stage, 2);
    sys_rstn = 1'b1;
    tick();
    tick();
    chk("gl_stage_sys_hold", stage, 2);
    tick();
    chk("gl_stage_core", stage, 3);
    tick();
    chk("gl_stage_done", stage, 4);
    chk("gl_total_remeas", total_cyc, 6);
    chk("gl_all_ready_back", all_ready, 1);
    chk("gl_fault_cnt_once", fault_cnt, 1);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk("clr_fault", fault, 0);
    chk("clr_fault_cnt", fault_cnt, 0);
    chk("clr_stage_kept", stage, 4);

    // Asynchronous reset while in WAIT_SYS
    reset_with(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (6) tick();
    chk("mid_stage_sys", stage, 2);
    chk("mid_total", total_cyc, 6);
    @(negedge clk);
    rstn_sig = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    rstn_sig = 1'b1;
    edge_n   = 0;
    tick();
    chk("rel_stage_0", stage, 0);
    chk("rel_total_1", total_cyc, 1);
    tick();
    tick();
    chk("rel_stage_1", stage, 1);
    chk("rel_total_3", total_cyc, 3);
    tick();
    chk("rel_stage_2", stage, 2);
    chk("rel_total_4", total_cyc, 4);

    // Timeout: WAIT_DDR entered at edge 3, timeout 64 edges later
    reset_with(1'b1, 1'b0, 1'b0, 1'b1);
    while (edge_n < 66) tick();
    chk("to_stage_pre", stage, 1);
    chk("to_flag_pre", timeout, 0);
    tick();
    chk("to_stage", stage, 5);
    chk("to_flag", timeout, 1);
    chk("to_all_ready", all_ready, 0);
    ddr_rstn   = 1'b1;
    sys_rstn   = 1'b1;
    core_reset = 1'b0;
    tick();
    tick();
    chk("to_stage_hold", stage, 5);
    tick();
    chk("to_stage_done", stage, 4);
    chk("to_flag_sticky", timeout, 1);
    chk("to_all_ready_done", all_ready, 1);
    chk("to_total", total_cyc, 70);
    chk("to_fault", fault, 0);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk("to_clr", timeout, 0);
    chk("to_clr_stage", stage, 4);

    // Order violation: sys released while cfg still held
    reset_with(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    chk("ov_fault_pre", fault, 0);
    tick();
    chk("ov_fault", fault, 1);
    chk("ov_cnt_first", fault_cnt, 1);
    while (edge_n < 52) tick();
    chk("ov_cnt_held", fault_cnt, 1);
    chk("ov_stage", stage, 0);
    sys_rstn = 1'b0;
    tick();
    tick();
    sys_rstn = 1'b1;
    tick();
    tick();
    chk("ov_cnt_rearm_pre", fault_cnt, 1);
    tick();
    chk("ov_cnt_rearm", fault_cnt, 2);

    // Saturation: 300 DONE glitches
    reset_with(1'b1, 1'b1, 1'b1, 1'b0);
    wait_stage(3'd4, 20);
    chk("sat_initial_done", stage, 4);
    for (int g = 0; g < 300; g++) begin
      sys_rstn = 1'b0;
      repeat (3) tick();
      sys_rstn = 1'b1;
      wait_stage(3'd4, 30);
      chk("sat_glitch_done", stage, 4);
    end
    chk("sat_cnt", fault_cnt, 255);
    chk("sat_fault", fault, 1);

    // Fault and clear on the same edge: the fault wins
    sys_rstn = 1'b0;
    tick();
    tick();
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    sys_rstn  = 1'b1;
    chk("fc_fault", fault, 1);
    chk("fc_cnt", fault_cnt, 1);
    chk("fc_stage", stage, 0);
    wait_stage(3'd4, 30);
    chk("fc_done_again", stage, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
